ahbl_splitter_n: RTL and testbench

Parametrised AHB-Lite address decoder and read-data multiplexer for NS slaves. It is the successor to the fixed 4-slave splitter and the GPIO sub-splitter, and sits between the Hazard2 master and the memories and peripherals. Each slave's region is set by a base/mask pair on the high address bits. It adds a built-in default slave that returns a two-cycle AHB ERROR response for unmapped accesses, and adds HRESP propagation.

---
 rtl/ahbl_splitter_n.sv | 141 ++++++++++++++
 tb/tb_ahbl_splitter_n.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite decoder/read mux for NS base/mask slaves with a built-in ERROR default slave.
// Optional AHBL_SPLITTER_TIMEOUT_EN: stalled mapped slaves are cut off with an ERROR and sticky timeout_err.
module ahbl_splitter_n #(
   parameter int NS      = 4,
   parameter int DEC_LSB = 28,
   parameter int DEC_W   = 4,
   parameter logic [NS*DEC_W-1:0] SLV_BASE = {4'h8, 4'h4, 4'h2, 4'h0},
   parameter logic [NS*DEC_W-1:0] SLV_MASK = '1,
   parameter int TIMEOUT = 64
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   output logic             HREADY,
   output logic             HRESP,
   output logic [31:0]      HRDATA,
   output logic [NS-1:0]    S_HSEL,
   input  logic [NS*32-1:0] S_HRDATA,
   input  logic [NS-1:0]    S_HREADYOUT,
   input  logic [NS-1:0]    S_HRESP
`ifdef AHBL_SPLITTER_TIMEOUT_EN
   ,
   output logic             timeout_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

   localparam logic [31:0] DEC_FMASK = ({32{1'b1}} >> (32 - DEC_W)) << DEC_LSB;

   if (NS < 1 || NS > 8 || TIMEOUT < 2) begin : g_bad_param
      $error("ahbl_splitter_n: illegal parameter combination");
   end

   logic [DEC_W-1:0] field;
   logic             found;
   logic [NS-1:0]    sel;
   logic [NS:0]      dsel_d, dsel_q;
   state_t           state_q;
   logic             def_rdy_q, def_err_q;
   logic             err_start;
   logic             to_fire;
   logic             unused_sig;

   assign field      = HADDR[DEC_LSB +: DEC_W];
   assign unused_sig = ^{HADDR & ~DEC_FMASK, HTRANS[0]};

   // Ascending scan with a found flag gives lowest-index priority on overlaps.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NS; i++) begin
         if (!found && ((field & SLV_MASK[i*DEC_W +: DEC_W]) ==
                        (SLV_BASE[i*DEC_W +: DEC_W] & SLV_MASK[i*DEC_W +: DEC_W]))) begin
            found  = 1'b1;
            sel[i] = 1'b1;
         end
      end
   end

   assign S_HSEL = sel;
   assign dsel_d = found ? {1'b0, sel} : {1'b1, {NS{1'b0}}};

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      for (int i = 0; i < NS; i++) begin
         if (dsel_q[i]) begin
            HREADY = S_HREADYOUT[i];
            HRESP  = S_HRESP[i];
            HRDATA = S_HRDATA[i*32 +: 32];
         end
      end
      if (dsel_q[NS]) begin
         HREADY = def_rdy_q;
         HRESP  = def_err_q;
         HRDATA = '0;
      end
   end

   assign err_start = (HREADY && !found && HTRANS[1]) || to_fire;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_q <= {1'b1, {NS{1'b0}}};
      end else if (to_fire) begin
         dsel_q <= {1'b1, {NS{1'b0}}};
      end else if (HREADY) begin
         dsel_q <= dsel_d;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= S_IDLE;
         def_rdy_q <= 1'b1;
         def_err_q <= 1'b0;
      end else if (state_q == S_ERR1) begin
         state_q   <= S_ERR2;
         def_rdy_q <= 1'b1;
         def_err_q <= 1'b1;
      end else if (err_start) begin
         state_q   <= S_ERR1;
         def_rdy_q <= 1'b0;
         def_err_q <= 1'b1;
      end else begin
         state_q   <= S_IDLE;
         def_rdy_q <= 1'b1;
         def_err_q <= 1'b0;
      end
   end

`ifdef AHBL_SPLITTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic          stall;
   logic          timeout_err_q;

   assign stall       = !dsel_q[NS] && !HREADY;
   assign to_fire     = stall && (cnt_q == TO_LAST);
   assign timeout_err = timeout_err_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (HREADY || to_fire) cnt_q <= '0;
         else if (stall)        cnt_q <= cnt_q + 1'b1;
         if (to_fire) timeout_err_q <= 1'b1;
      end
   end
`else
   assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: decode, wait states, default-slave ERROR pairs, mask/overlap, reset abort.
module tb_ahbl_splitter_n;
   logic          HCLK;
   logic          HRESETn;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HREADY, HRESP;
   logic [31:0]   HRDATA;
   logic [3:0]    S_HSEL;
   logic [127:0]  S_HRDATA;
   logic [3:0]    S_HREADYOUT;
   logic [3:0]    S_HRESP;
   logic          b_rdy, b_resp;
   logic [31:0]   b_rdata;
   logic [3:0]    b_sel;
`ifdef AHBL_SPLITTER_TIMEOUT_EN
   logic          timeout_err, b_to_err;
`endif
   int            n_cmp = 0;
   int            n_err = 0;

   ahbl_splitter_n #(.TIMEOUT(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .S_HSEL(S_HSEL),
      .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP)
`ifdef AHBL_SPLITTER_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   // Slice1 mask 4'hE with base 2; slice3 base 2 overlaps slice1.
   ahbl_splitter_n #(.SLV_BASE(16'h2420), .SLV_MASK(16'hFFEF), .TIMEOUT(8)) dut_b (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(b_rdy), .HRESP(b_resp), .HRDATA(b_rdata), .S_HSEL(b_sel),
      .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP)
`ifdef AHBL_SPLITTER_TIMEOUT_EN
      , .timeout_err(b_to_err)
`endif
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task tick;
      @(posedge HCLK);
      #1;
   endtask

   task settle;
      #4;
   endtask

   task test_reset;
      HRESETn = 1'b0; HADDR = 32'h0; HTRANS = 2'b00;
      S_HRDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      S_HREADYOUT = 4'hF; S_HRESP = 4'h0;
      #12;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL rst_in_reset got %b/%b/%h want 1/0/00000000", HREADY, HRESP, HRDATA);
      end
      tick;
      HRESETn = 1'b1;
      settle;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA, S_HSEL} !== {1'b1, 1'b0, 32'h0, 4'b0001}) begin
         n_err++; $display("FAIL rst_release got %b/%b/%h sel=%b want 1/0/00000000 sel=0001", HREADY, HRESP, HRDATA, S_HSEL);
      end
   endtask

   task test_mapped_read;
      tick;
      HADDR = 32'h2000_0010; HTRANS = 2'b10; S_HREADYOUT[1] = 1'b0;
      settle;
      n_cmp++;
      if ({S_HSEL, HREADY} !== {4'b0010, 1'b1}) begin
         n_err++; $display("FAIL rd_addr got sel=%b rdy=%b want sel=0010 rdy=1", S_HSEL, HREADY);
      end
      tick;
      HTRANS = 2'b00; HADDR = 32'hF000_0000;
      settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b00) begin
         n_err++; $display("FAIL rd_wait1 got %b/%b want 0/0", HREADY, HRESP);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b00) begin
         n_err++; $display("FAIL rd_wait2 got %b/%b want 0/0", HREADY, HRESP);
      end
      tick;
      S_HREADYOUT[1] = 1'b1; S_HRDATA[63:32] = 32'hDEAD_BEEF;
      settle;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
         n_err++; $display("FAIL rd_data got %b/%b/%h want 1/0/deadbeef", HREADY, HRESP, HRDATA);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL rd_idle_after got %b/%b/%h want 1/0/00000000", HREADY, HRESP, HRDATA);
      end
      S_HRDATA[63:32] = 32'h1111_1111;
   endtask

   task test_unmapped;
      tick;
      HADDR = 32'hF000_0000; HTRANS = 2'b10;
      settle;
      n_cmp++;
      if ({S_HSEL, HREADY, HRESP} !== {4'b0000, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL um_addr got sel=%b %b/%b want sel=0000 1/0", S_HSEL, HREADY, HRESP);
      end
      tick;
      HTRANS = 2'b00;
      settle;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b0, 1'b1, 32'h0}) begin
         n_err++; $display("FAIL um_err1 got %b/%b/%h want 0/1/00000000", HREADY, HRESP, HRDATA);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b11) begin
         n_err++; $display("FAIL um_err2 got %b/%b want 1/1", HREADY, HRESP);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b10) begin
         n_err++; $display("FAIL um_okay got %b/%b want 1/0", HREADY, HRESP);
      end
   endtask

   task test_back_to_back;
      tick;
      HADDR = 32'hF000_0000; HTRANS = 2'b10;
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b01) begin
         n_err++; $display("FAIL b2b_err1a got %b/%b want 0/1", HREADY, HRESP);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b11) begin
         n_err++; $display("FAIL b2b_err2a got %b/%b want 1/1", HREADY, HRESP);
      end
      tick;
      HADDR = 32'h4000_0000; HTRANS = 2'b10;
      settle;
      n_cmp++;
      if ({HREADY, HRESP, S_HSEL} !== {1'b0, 1'b1, 4'b0100}) begin
         n_err++; $display("FAIL b2b_err1b got %b/%b sel=%b want 0/1 sel=0100", HREADY, HRESP, S_HSEL);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b11) begin
         n_err++; $display("FAIL b2b_err2b got %b/%b want 1/1", HREADY, HRESP);
      end
      tick;
      HTRANS = 2'b00; HADDR = 32'hF000_0000;
      settle;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h2222_2222}) begin
         n_err++; $display("FAIL b2b_mapped got %b/%b/%h want 1/0/22222222", HREADY, HRESP, HRDATA);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL b2b_idle got %b/%b/%h want 1/0/00000000", HREADY, HRESP, HRDATA);
      end
   endtask

   task test_reset_abort;
      tick;
      HADDR = 32'hF000_0000; HTRANS = 2'b10;
      tick;
      HTRANS = 2'b00;
      settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b01) begin
         n_err++; $display("FAIL abort_pre got %b/%b want 0/1", HREADY, HRESP);
      end
      #1 HRESETn = 1'b0;
      #1;
      n_cmp++;
      if ({HREADY, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL abort_rst got %b/%b/%h want 1/0/00000000", HREADY, HRESP, HRDATA);
      end
      tick;
      HRESETn = 1'b1;
      settle;
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b10) begin
         n_err++; $display("FAIL abort_post got %b/%b want 1/0", HREADY, HRESP);
      end
   endtask

   task test_mask_overlap;
      tick;
      HTRANS = 2'b00; HADDR = 32'h3000_0000;
      settle;
      n_cmp++;
      if (b_sel !== 4'b0010) begin
         n_err++; $display("FAIL mask_3 got %b want 0010", b_sel);
      end
      n_cmp++;
      if (S_HSEL !== 4'b0000) begin
         n_err++; $display("FAIL fullmask_3 got %b want 0000", S_HSEL);
      end
      tick;
      HADDR = 32'h2ABC_0000;
      settle;
      n_cmp++;
      if (b_sel !== 4'b0010) begin
         n_err++; $display("FAIL overlap_2 got %b want 0010", b_sel);
      end
      tick;
      HADDR = 32'h8000_0000;
      settle;
      n_cmp++;
      if ({b_sel, S_HSEL} !== {4'b0000, 4'b1000}) begin
         n_err++; $display("FAIL sel_8 got b=%b a=%b want b=0000 a=1000", b_sel, S_HSEL);
      end
      tick;
      HADDR = 32'hF000_0000;
   endtask

`ifdef AHBL_SPLITTER_TIMEOUT_EN
   task test_timeout;
      tick;
      HADDR = 32'h0000_0000; HTRANS = 2'b10; S_HREADYOUT[0] = 1'b0;
      tick;
      HTRANS = 2'b00; HADDR = 32'hF000_0000;
      for (int k = 0; k < 7; k++) tick;
      settle;
      n_cmp++;
      if ({HREADY, HRESP, timeout_err} !== 3'b000) begin
         n_err++; $display("FAIL to_stall8 got %b/%b/%b want 0/0/0", HREADY, HRESP, timeout_err);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP, timeout_err} !== 3'b011) begin
         n_err++; $display("FAIL to_err1 got %b/%b/%b want 0/1/1", HREADY, HRESP, timeout_err);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP, timeout_err} !== 3'b111) begin
         n_err++; $display("FAIL to_err2 got %b/%b/%b want 1/1/1", HREADY, HRESP, timeout_err);
      end
      tick; settle;
      n_cmp++;
      if ({HREADY, HRESP, timeout_err} !== 3'b101) begin
         n_err++; $display("FAIL to_sticky got %b/%b/%b want 1/0/1", HREADY, HRESP, timeout_err);
      end
      S_HREADYOUT[0] = 1'b1;
      HRESETn = 1'b0;
      tick;
      HRESETn = 1'b1;
      settle;
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_err++; $display("FAIL to_clear got %b want 0", timeout_err);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_mapped_read;
      test_unmapped;
      test_back_to_back;
      test_reset_abort;
      test_mask_overlap;
`ifdef AHBL_SPLITTER_TIMEOUT_EN
      test_timeout;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
